// File: rtl/multicycle_ctl_pkg.sv
// multicycle_ctl_pkg: MIPS opcodes, R-type functs, ALU op codes and sequencer states
package multicycle_ctl_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic legal_opcode(input logic [5:0] o);
        return o inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/multicycle_ctl_if.sv
// multicycle_ctl_if: datapath-facing inputs and control strobes of the sequencer
interface multicycle_ctl_if;
    logic        stall;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        int_load;
    logic        ir_we;
    logic        pc_we;
    logic        RegDst;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Mem2Reg;
    logic        branch;
    logic        jump;
    logic [2:0]  op;
    logic [31:0] instr_cnt;
    logic        halted;
    logic        illegal;

    modport master (
        input  stall, opcode, funct, zero,
        output int_load, ir_we, pc_we, RegDst, ALUSrc, RegWrite, MemRead, MemWrite,
               Mem2Reg, branch, jump, op, instr_cnt, halted, illegal
    );

    modport slave (
        output stall, opcode, funct, zero,
        input  int_load, ir_we, pc_we, RegDst, ALUSrc, RegWrite, MemRead, MemWrite,
               Mem2Reg, branch, jump, op, instr_cnt, halted, illegal
    );
endinterface

// File: rtl/multicycle_ctl_alu_op_decode.sv
// multicycle_ctl_alu_op_decode: opcode/funct to ALU op, flags unsupported R-type funct
module multicycle_ctl_alu_op_decode
    import multicycle_ctl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] op,
    output logic       illegal_funct
);
    always_comb begin
        op = (opcode == OP_BEQ) ? ALU_SUB : ALU_ADD;
        illegal_funct = 1'b0;
        if (opcode == OP_R) begin
            case (funct)
                F_AND:   op = ALU_AND;
                F_OR:    op = ALU_OR;
                F_ADD:   op = ALU_ADD;
                F_SUB:   op = ALU_SUB;
                F_SLT:   op = ALU_SLT;
                default: illegal_funct = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_ctl.sv
// multicycle_ctl: multi-cycle MIPS sequencer issuing per-phase strobes and counting retirements
module multicycle_ctl
    import multicycle_ctl_pkg::*;
#(
    parameter logic [31:0] MAX_INSTR = 32'd0
) (
    input logic              clk,
    input logic              rst,
    multicycle_ctl_if.master bus
);
    state_t      state_q, state_d, ret_state;
    logic [31:0] cnt_q, cnt_d;
    logic        illegal_q, illegal_d;
    logic [2:0]  dec_op;
    logic        bad_funct;
    logic        is_r, is_j, is_beq, is_lw, is_sw, is_imm, bad;
    logic        quiet, in_ins, short_ret, retire;

    multicycle_ctl_alu_op_decode u_dec (
        .opcode        (bus.opcode),
        .funct         (bus.funct),
        .op            (dec_op),
        .illegal_funct (bad_funct)
    );

    // a reset cycle is treated like a stall so the abandoned instruction writes nothing
    always_comb begin
        is_r      = bus.opcode == OP_R;
        is_j      = bus.opcode == OP_J;
        is_beq    = bus.opcode == OP_BEQ;
        is_lw     = bus.opcode == OP_LW;
        is_sw     = bus.opcode == OP_SW;
        is_imm    = bus.opcode inside {OP_ADDI, OP_LW, OP_SW};
        bad       = !legal_opcode(bus.opcode) || (is_r && bad_funct);
        quiet     = rst || bus.stall;
        in_ins    = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};
        short_ret = is_beq || is_j || bad;
        retire    = !quiet && ((state_q == S_EXEC && short_ret) || (state_q == S_MEM && is_sw) ||
                               state_q == S_WB);
        ret_state = (MAX_INSTR != 32'd0 && cnt_q + 32'd1 == MAX_INSTR) ? S_HALT : S_FETCH;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = short_ret ? ret_state : (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:    state_d = is_lw ? S_WB : ret_state;
            S_WB:     state_d = ret_state;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
        state_d   = bus.stall ? state_q : state_d;
        cnt_d     = cnt_q + {31'd0, retire};
        illegal_d = illegal_q || (!quiet && state_q == S_EXEC && bad);
    end

    always_comb begin
        bus.int_load  = !quiet && state_q == S_INIT;
        bus.ir_we     = !quiet && state_q == S_FETCH;
        bus.pc_we     = retire;
        bus.RegDst    = in_ins && is_r;
        bus.ALUSrc    = in_ins && is_imm;
        bus.RegWrite  = !quiet && state_q == S_WB;
        bus.MemRead   = !quiet && state_q == S_MEM && is_lw;
        bus.MemWrite  = !quiet && state_q == S_MEM && is_sw;
        bus.Mem2Reg   = state_q == S_WB && is_lw;
        bus.branch    = state_q == S_EXEC && is_beq;
        bus.jump      = state_q == S_EXEC && is_j;
        bus.op        = (state_q == S_EXEC) ? dec_op : ALU_ADD;
        bus.instr_cnt = cnt_q;
        bus.halted    = state_q == S_HALT;
        bus.illegal   = illegal_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INIT;
            cnt_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctl.sv
// tb_multicycle_ctl: vector table, corner sequences and a random run against a phase-schedule model
module tb_multicycle_ctl;
    localparam logic [12:0] K_IL  = 13'h1000;
    localparam logic [12:0] K_IR  = 13'h0800;
    localparam logic [12:0] K_PC  = 13'h0400;
    localparam logic [12:0] K_RD  = 13'h0200;
    localparam logic [12:0] K_AS  = 13'h0100;
    localparam logic [12:0] K_RW  = 13'h0080;
    localparam logic [12:0] K_MR  = 13'h0040;
    localparam logic [12:0] K_MW  = 13'h0020;
    localparam logic [12:0] K_M2R = 13'h0010;
    localparam logic [12:0] K_BR  = 13'h0008;
    localparam logic [12:0] K_JP  = 13'h0004;
    localparam logic [12:0] K_HLT = 13'h0002;
    localparam logic [12:0] K_ILL = 13'h0001;
    localparam logic [12:0] K_GATED = K_IL | K_IR | K_PC | K_RW | K_MW | K_MR;

    typedef struct {
        logic        st;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [12:0] es;
        logic [2:0]  eo;
        logic [31:0] ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] act_m, act_h;
    logic [31:0] ecnt;
    logic        ill;
    int          tests = 0;
    int          fails = 0;
    vec_t        tv[$];

    always #5 clk = ~clk;

    multicycle_ctl_if m ();
    multicycle_ctl_if h ();

    multicycle_ctl #(.MAX_INSTR(32'd0)) dut (.clk(clk), .rst(rst), .bus(m.master));
    multicycle_ctl #(.MAX_INSTR(32'd3)) dut_h (.clk(clk), .rst(rst), .bus(h.master));

    assign act_m = {m.int_load, m.ir_we, m.pc_we, m.RegDst, m.ALUSrc, m.RegWrite, m.MemRead,
                    m.MemWrite, m.Mem2Reg, m.branch, m.jump, m.halted, m.illegal};
    assign act_h = {h.int_load, h.ir_we, h.pc_we, h.RegDst, h.ALUSrc, h.RegWrite, h.MemRead,
                    h.MemWrite, h.Mem2Reg, h.branch, h.jump, h.halted, h.illegal};

    function automatic vec_t mk(input logic st, input logic [5:0] opc, input logic [5:0] fn,
                                input logic [12:0] es, input logic [2:0] eo, input logic [31:0] ec);
        vec_t v;
        v.st = st; v.opc = opc; v.fn = fn; v.es = es; v.eo = eo; v.ec = ec;
        return v;
    endfunction

    // reference model: each instruction is a fixed schedule of phases k = 0 (fetch) .. len-1 (retire)
    function automatic logic bad_of(input logic [5:0] opc, input logic [5:0] fn);
        return !(opc inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2b}) ||
               (opc == 6'h00 && !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}));
    endfunction

    function automatic int ilen(input logic [5:0] opc, input logic [5:0] fn);
        if (bad_of(opc, fn) || opc == 6'h02 || opc == 6'h04) return 3;
        return (opc == 6'h23) ? 5 : 4;
    endfunction

    function automatic logic [2:0] op_of(input logic [5:0] opc, input logic [5:0] fn);
        if (opc == 6'h04) return 3'b110;
        if (opc != 6'h00) return 3'b010;
        case (fn)
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h22:   return 3'b110;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [12:0] exp_strb(input int k, input logic [5:0] opc, input logic [5:0] fn,
                                             input logic st, input logic il);
        logic [12:0] s;
        int n;
        logic last;
        n = ilen(opc, fn);
        last = (k == n - 1);
        s = 13'h0;
        if (k == 0) s |= K_IR;
        if (last) s |= K_PC;
        if (k >= 1 && opc == 6'h00) s |= K_RD;
        if (k >= 1 && opc inside {6'h08, 6'h23, 6'h2b}) s |= K_AS;
        if (last && !bad_of(opc, fn) && opc inside {6'h00, 6'h08, 6'h23}) s |= K_RW;
        if (k == 3 && opc == 6'h23) s |= K_MR;
        if (k == 3 && opc == 6'h2b) s |= K_MW;
        if (k == 4 && opc == 6'h23) s |= K_M2R;
        if (k == 2 && opc == 6'h04) s |= K_BR;
        if (k == 2 && opc == 6'h02) s |= K_JP;
        if (il) s |= K_ILL;
        if (st) s &= ~K_GATED;
        return s;
    endfunction

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got strobes/op/cnt %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [5:0] opc, input logic [5:0] fn);
        m.stall = st; m.opcode = opc; m.funct = fn; m.zero = 1'($urandom_range(0, 1));
        h.stall = st; h.opcode = opc; h.funct = fn; h.zero = m.zero;
    endtask

    task automatic cyc(input string nm, input logic st, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [12:0] es, input logic [2:0] eo, input logic [31:0] ec,
                       input logic use_h);
        drive(st, opc, fn);
        #1;
        if (use_h) check(nm, {act_h, h.op, h.instr_cnt}, {es, eo, ec});
        else check(nm, {act_m, m.op, m.instr_cnt}, {es, eo, ec});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 6'h00, 6'h20);
        @(posedge clk);
        #1;
        check("reset_hold", {act_m, m.op, m.instr_cnt}, {13'h0, 3'b010, 32'd0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        ecnt = 32'd0;
        ill = 1'b0;
    endtask

    initial begin
        logic [5:0] opc, fn;
        logic [5:0] fl[5];
        int n, ns;
        fl = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2a};

        tv.push_back(mk(0, 6'h00, 6'h20, K_IL, 3'b010, 0));
        tv.push_back(mk(0, 6'h00, 6'h20, K_IR, 3'b010, 0));
        tv.push_back(mk(0, 6'h00, 6'h20, K_RD, 3'b010, 0));
        tv.push_back(mk(0, 6'h00, 6'h20, K_RD, 3'b010, 0));
        tv.push_back(mk(0, 6'h00, 6'h20, K_RD | K_RW | K_PC, 3'b010, 0));
        tv.push_back(mk(0, 6'h23, 6'h00, K_IR, 3'b010, 1));
        tv.push_back(mk(0, 6'h23, 6'h00, K_AS, 3'b010, 1));
        tv.push_back(mk(0, 6'h23, 6'h00, K_AS, 3'b010, 1));
        tv.push_back(mk(0, 6'h23, 6'h00, K_AS | K_MR, 3'b010, 1));
        tv.push_back(mk(0, 6'h23, 6'h00, K_AS | K_RW | K_M2R | K_PC, 3'b010, 1));
        tv.push_back(mk(0, 6'h2b, 6'h00, K_IR, 3'b010, 2));
        tv.push_back(mk(0, 6'h2b, 6'h00, K_AS, 3'b010, 2));
        tv.push_back(mk(0, 6'h2b, 6'h00, K_AS, 3'b010, 2));
        tv.push_back(mk(0, 6'h2b, 6'h00, K_AS | K_MW | K_PC, 3'b010, 2));
        tv.push_back(mk(0, 6'h04, 6'h00, K_IR, 3'b010, 3));
        tv.push_back(mk(0, 6'h04, 6'h00, 13'h0, 3'b010, 3));
        tv.push_back(mk(0, 6'h04, 6'h00, K_BR | K_PC, 3'b110, 3));
        tv.push_back(mk(0, 6'h02, 6'h00, K_IR, 3'b010, 4));
        tv.push_back(mk(0, 6'h02, 6'h00, 13'h0, 3'b010, 4));
        tv.push_back(mk(0, 6'h02, 6'h00, K_JP | K_PC, 3'b010, 4));
        tv.push_back(mk(0, 6'h00, 6'h22, K_IR, 3'b010, 5));
        tv.push_back(mk(0, 6'h00, 6'h22, K_RD, 3'b010, 5));
        tv.push_back(mk(0, 6'h00, 6'h22, K_RD, 3'b110, 5));
        tv.push_back(mk(0, 6'h00, 6'h22, K_RD | K_RW | K_PC, 3'b010, 5));
        tv.push_back(mk(0, 6'h3f, 6'h00, K_IR, 3'b010, 6));
        tv.push_back(mk(0, 6'h3f, 6'h00, 13'h0, 3'b010, 6));
        tv.push_back(mk(0, 6'h3f, 6'h00, K_PC, 3'b010, 6));
        tv.push_back(mk(0, 6'h08, 6'h00, K_IR | K_ILL, 3'b010, 7));
        tv.push_back(mk(0, 6'h08, 6'h00, K_AS | K_ILL, 3'b010, 7));
        tv.push_back(mk(0, 6'h08, 6'h00, K_AS | K_ILL, 3'b010, 7));
        tv.push_back(mk(0, 6'h08, 6'h00, K_AS | K_RW | K_PC | K_ILL, 3'b010, 7));
        tv.push_back(mk(0, 6'h00, 6'h3f, K_IR | K_ILL, 3'b010, 8));
        tv.push_back(mk(0, 6'h00, 6'h3f, K_RD | K_ILL, 3'b010, 8));
        tv.push_back(mk(0, 6'h00, 6'h3f, K_RD | K_PC | K_ILL, 3'b010, 8));
        tv.push_back(mk(0, 6'h00, 6'h2a, K_IR | K_ILL, 3'b010, 9));
        tv.push_back(mk(0, 6'h00, 6'h2a, K_RD | K_ILL, 3'b010, 9));
        tv.push_back(mk(0, 6'h00, 6'h2a, K_RD | K_ILL, 3'b111, 9));
        tv.push_back(mk(0, 6'h00, 6'h2a, K_RD | K_RW | K_PC | K_ILL, 3'b010, 9));
        tv.push_back(mk(0, 6'h23, 6'h00, K_IR | K_ILL, 3'b010, 10));

        do_reset();
        foreach (tv[i]) cyc($sformatf("vec%0d", i), tv[i].st, tv[i].opc, tv[i].fn, tv[i].es, tv[i].eo,
                            tv[i].ec, 1'b0);

        // lw held in MEM by a 3-cycle stall, then completes
        cyc("stall_lw_dec", 0, 6'h23, 6'h00, K_AS | K_ILL, 3'b010, 10, 1'b0);
        cyc("stall_lw_exec", 0, 6'h23, 6'h00, K_AS | K_ILL, 3'b010, 10, 1'b0);
        for (int i = 0; i < 3; i++) cyc("stall_lw_mem_held", 1, 6'h23, 6'h00, K_AS | K_ILL, 3'b010, 10, 1'b0);
        cyc("stall_lw_mem", 0, 6'h23, 6'h00, K_AS | K_MR | K_ILL, 3'b010, 10, 1'b0);
        cyc("stall_lw_wb", 0, 6'h23, 6'h00, K_AS | K_RW | K_M2R | K_PC | K_ILL, 3'b010, 10, 1'b0);
        cyc("stall_lw_next", 0, 6'h00, 6'h20, K_IR | K_ILL, 3'b010, 11, 1'b0);

        // reset arriving in EXEC abandons the add without any write
        cyc("rst_exec_dec", 0, 6'h00, 6'h20, K_RD | K_ILL, 3'b010, 11, 1'b0);
        drive(1'b0, 6'h00, 6'h20);
        rst = 1'b1;
        #1;
        check("rst_exec_nowrite", {act_m & K_GATED, m.instr_cnt}, {13'h0, 32'd11});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rst_to_init", 0, 6'h00, 6'h20, K_IL, 3'b010, 0, 1'b0);

        // MAX_INSTR=3 instance: three adds then HALT
        for (int i = 0; i < 3; i++) begin
            cyc("halt_fetch", 0, 6'h00, 6'h20, K_IR, 3'b010, i, 1'b1);
            cyc("halt_dec", 0, 6'h00, 6'h20, K_RD, 3'b010, i, 1'b1);
            cyc("halt_exec", 0, 6'h00, 6'h20, K_RD, 3'b010, i, 1'b1);
            cyc("halt_wb", 0, 6'h00, 6'h20, K_RD | K_RW | K_PC, 3'b010, i, 1'b1);
        end
        for (int i = 0; i < 3; i++) cyc("halted", 0, 6'h00, 6'h20, K_HLT, 3'b010, 3, 1'b1);

        // random instruction stream with random stalls
        do_reset();
        cyc("rand_init", 0, 6'h00, 6'h20, K_IL, 3'b010, 0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin opc = 6'h00; fn = fl[$urandom_range(0, 4)]; end
                4: begin opc = 6'h00; fn = 6'($urandom_range(0, 63)); end
                5: begin opc = 6'h02; fn = 6'($urandom_range(0, 63)); end
                6: begin opc = 6'h04; fn = 6'($urandom_range(0, 63)); end
                7: begin opc = 6'h08; fn = 6'($urandom_range(0, 63)); end
                8: begin opc = $urandom_range(0, 1) ? 6'h23 : 6'h2b; fn = 6'($urandom_range(0, 63)); end
                default: begin opc = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
            endcase
            n = ilen(opc, fn);
            for (int k = 0; k < n; k++) begin
                ns = 0;
                while (ns < 3 && $urandom_range(0, 4) == 0) begin
                    cyc("rand_stall", 1, opc, fn, exp_strb(k, opc, fn, 1'b1, ill),
                        (k == 2) ? op_of(opc, fn) : 3'b010, ecnt, 1'b0);
                    ns++;
                end
                cyc("rand", 0, opc, fn, exp_strb(k, opc, fn, 1'b0, ill),
                    (k == 2) ? op_of(opc, fn) : 3'b010, ecnt, 1'b0);
                if (k == n - 1) begin
                    ecnt++;
                    if (bad_of(opc, fn)) ill = 1'b1;
                end
            end
        end
        cyc("rand_end", 0, 6'h00, 6'h20, K_IR | (ill ? K_ILL : 13'h0), 3'b010, ecnt, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
